// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the polynomial coefficient-wise datapath blocks.
package ntt_pkg;

    localparam int unsigned DefDataWidth = 14;
    localparam int unsigned DefAddrWidth = 9;
    localparam int unsigned DefN         = 512;
    localparam int unsigned DefM         = 12289;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/poly_sub_lane.sv
// Registered modular subtract (op=0) or add (op=1) of one coefficient pair.
module poly_sub_lane
    import ntt_pkg::*;
#(
    parameter int unsigned data_width = DefDataWidth,
    parameter int unsigned M          = DefM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  op,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic [data_width-1:0] y
);

    // Two guard bits hold a+b and a-b+M without overflow before truncation.
    localparam int unsigned W = data_width + 2;

    logic [W-1:0] a_ext, b_ext, mod_ext;
    logic [W-1:0] diff, sum, res;
    logic         unused_res_hi;

    always_comb begin
        a_ext   = W'(a);
        b_ext   = W'(b);
        mod_ext = W'(M);
        diff    = a_ext - b_ext;
        sum     = a_ext + b_ext;
        res     = diff;
        if (op) begin
            res = (sum >= mod_ext) ? (sum - mod_ext) : sum;
        end else if (a < b) begin
            res = diff + mod_ext;
        end
    end

    assign unused_res_hi = ^res[W-1:data_width];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y <= res[data_width-1:0];
        end
    end

endmodule

// File: rtl/poly_sub_ctrl.sv
// Streams one polynomial pass through poly_sub_lane: reads A/B, writes (a-b) mod M.
// Define POLY_SUB_ADD_EN to add an 'op' port selecting (a+b) mod M per pass.
module poly_sub_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned data_width = DefDataWidth,
    parameter int unsigned addr_width = DefAddrWidth,
    parameter int unsigned N          = DefN,
    parameter int unsigned M          = DefM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef POLY_SUB_ADD_EN
    input  logic                  op,
`endif
    output logic                  rd_en,
    output logic [addr_width-1:0] rd_addr,
    input  logic [data_width-1:0] a_data,
    input  logic [data_width-1:0] b_data,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [addr_width-1:0] LastAddr = addr_width'(N - 1);

    state_e                state;
    logic                  drain_cnt;
    logic                  op_q;
    logic                  op_in;
    logic                  rd_en_d1;
    logic [addr_width-1:0] rd_addr_d1;

`ifdef POLY_SUB_ADD_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= 1'b0;
            op_q      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StRun;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        op_q    <= op_in;
                    end
                end
                StRun: begin
                    if (rd_addr == LastAddr) begin
                        state     <= StDrain;
                        rd_en     <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + addr_width'(1);
                    end
                end
                // Two cycles cover memory read latency plus the lane register.
                StDrain: begin
                    if (drain_cnt) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    done    <= 1'b0;
                    rd_addr <= '0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d1   <= 1'b0;
            rd_addr_d1 <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
        end else begin
            rd_en_d1   <= rd_en;
            rd_addr_d1 <= rd_addr;
            wr_en      <= rd_en_d1;
            if (rd_en_d1) begin
                wr_addr <= rd_addr_d1;
            end
        end
    end

    poly_sub_lane #(
        .data_width(data_width),
        .M         (M)
    ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (rd_en_d1),
        .op   (op_q),
        .a    (a_data),
        .b    (b_data),
        .y    (wr_data)
    );

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Self-checking bench for poly_sub_ctrl: cycle-timeline model plus literal result pins.
module tb_poly_sub_ctrl;

    localparam int DW = 14;
    localparam int AW = 9;
    localparam int NN = 512;
    localparam int MM = 12289;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
`ifdef POLY_SUB_ADD_EN
    logic          op = 1'b0;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    int mem_a[NN];
    int mem_b[NN];
    int res[NN];
    int wr_cnt = 0;
    int done_cnt = 0;

    // Model: m_t = cycle index within the current pass (1 = first read), -1 when idle.
    int m_t = -1;
    bit m_op = 1'b0;
    int last_wa = 0;
    int last_wd = 0;

    always #5 clk = ~clk;

    poly_sub_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef POLY_SUB_ADD_EN
        .op     (op),
`endif
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .a_data (a_data),
        .b_data (b_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy),
        .done   (done)
    );

    // Operand memories with one cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= DW'(mem_a[rd_addr]);
            b_data <= DW'(mem_b[rd_addr]);
        end
    end

    function automatic int model_f(int a, int b, bit add);
        int r;
        if (add) begin
            r = a + b;
            if (r >= MM) r = r - MM;
        end else begin
            r = (a >= b) ? (a - b) : (a - b + MM);
        end
        return r & ((1 << DW) - 1);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = -1;
        end else if (m_t >= 1) begin
            m_t = m_t + 1;
            if (m_t > NN + 3) m_t = -1;
        end else if (start) begin
            m_t = 1;
`ifdef POLY_SUB_ADD_EN
            m_op = op;
`else
            m_op = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_wa = 0;
            last_wd = 0;
            check("rst_rd_en", rd_en, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end else begin
            bit e_rd, e_wr;
            e_rd = (m_t >= 1) && (m_t <= NN);
            e_wr = (m_t >= 3) && (m_t <= NN + 2);
            check("rd_en", rd_en, e_rd);
            if (e_rd) check("rd_addr", rd_addr, m_t - 1);
            else if (m_t < 0) check("rd_addr_idle", rd_addr, 0);
            check("wr_en", wr_en, e_wr);
            if (e_wr) begin
                last_wa = m_t - 3;
                last_wd = model_f(mem_a[m_t - 3], mem_b[m_t - 3], m_op);
            end
            check("wr_addr", wr_addr, last_wa);
            check("wr_data", wr_data, last_wd);
            check("busy", busy, (m_t >= 1) && (m_t <= NN + 2));
            check("done", done, m_t == NN + 3);
            if (wr_en) begin
                res[wr_addr] = wr_data;
                wr_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_results();
        for (int i = 0; i < NN; i++) res[i] = -1;
        wr_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check(name, done, 1);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int k = 0; k < NN; k++) begin
            mem_a[k] = k;
            mem_b[k] = 2 * k;
        end
        repeat (3) tick();
        check("reset_rd_addr", rd_addr, 0);
        check("reset_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Pass 1: A[k]=k, B[k]=2k; second start at cycle 100 must be ignored.
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("pass1_done");
        check("pass1_writes", wr_cnt, 512);
        check("pass1_res0", res[0], 0);
        check("pass1_res1", res[1], 12288);
        check("pass1_res511", res[511], 11778);

        // Pass 2 back-to-back: start held through DONE, accepted in the idle cycle after.
        mem_a[0] = 0;     mem_b[0] = 12288;
        mem_a[1] = 12288; mem_b[1] = 0;
        mem_a[2] = 5000;  mem_b[2] = 5000;
        mem_a[3] = 16383; mem_b[3] = 0;
        mem_a[4] = 0;     mem_b[4] = 16383;
        for (int k = 5; k < NN; k++) begin
            mem_a[k] = int'($urandom_range(0, MM - 1));
            mem_b[k] = int'($urandom_range(0, MM - 1));
        end
        clear_results();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("pass2_rd_en_after_gap", rd_en, 1);
        check("pass2_rd_addr_first", rd_addr, 0);
        wait_done("pass2_done");
        check("pass2_writes", wr_cnt, 512);
        check("pass2_done_count", done_cnt, 1);
        check("bnd_0_minus_max", res[0], 1);
        check("bnd_max_minus_0", res[1], 12288);
        check("bnd_equal", res[2], 0);
        check("bnd_oor_a", res[3], 16383);
        check("bnd_oor_b", res[4], 12290);
        repeat (3) tick();

        // Pass 3: reset mid-pass, nothing may resume afterwards.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (199) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rd_en", rd_en, 0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_results();
        repeat (600) tick();
        check("postrst_writes", wr_cnt, 0);
        check("postrst_done", done_cnt, 0);

`ifdef POLY_SUB_ADD_EN
        // op sampled with start; toggling it mid-pass must not matter.
        mem_a[0] = 12000; mem_b[0] = 1000;
        clear_results();
        op = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 1'b0;
        wait_done("add_done");
        check("add_res0", res[0], 711);
        tick();
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 1'b1;
        wait_done("sub_done");
        check("sub_res0", res[0], 11000);
        op = 1'b0;
        repeat (2) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
